washer_processor: RTL and testbench
===================================

Name: washer_processor

Overview:
- Tiny sequencer core for the washing-machine controller.
- Fetches a 32-bit instruction addressed by an 8-bit pc from external program memory.
- Timed actuator instructions (fill, release, forward, reverse) drive one-hot control outputs for a programmed number of cycles.
- A small register file plus set/dec/jz/jnz instructions implements loops.

Parameters:
- NUM_REGS, 4, number of 16-bit general registers; register index field is compared against this.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  global run enable; 0 = pause.
- instr  input  32  instruction at address pc; combinational memory, valid in the same cycle.
- pc  output  8  program counter / instruction address.
- ctrl_fill  output  1  water inlet valve.
- ctrl_release  output  1  drain valve.
- ctrl_forward  output  1  motor forward.
- ctrl_reverse  output  1  motor reverse.

Behaviour:
- Instruction fields: op = instr[7:0], rsel = instr[15:8], imm = instr[31:16]; jump target = imm[7:0].
- Opcodes:
  - 01 wait
  - 02 fill
  - 03 release
  - 04 forward
  - 05 reverse
  - 11 set: R[rsel] = imm
  - 12 dec: R[rsel] = R[rsel]-1
  - 21 jz: if R[rsel]==0 then pc = target, else pc+1
  - 22 jnz: if R[rsel]!=0 then pc = target, else pc+1
- Any other opcode is a NOP (pc+1).
- Reset (async, rst=1):
  - pc=0, state=FETCH, counter=0.
  - All registers 0.
  - All ctrl_* outputs 0.
- States: FETCH and EXEC.
- FETCH (1 cycle), decodes instr:
  - Timed op (01-05), imm>0: latch op, counter=imm, go to EXEC; pc unchanged.
  - Timed op, imm=0: pc+1, stay in FETCH, no control pulse.
  - set/dec/jz/jnz/NOP: execute, update pc, stay in FETCH (one cycle per instruction).
- EXEC:
  - The ctrl output for the latched op is 1 (wait drives none); the other outputs are 0.
  - counter decrements each cycle.
  - When counter==1: pc+1 and return to FETCH.
- Timing: a timed op with duration D>0 occupies exactly D+1 cycles; its ctrl output is high for exactly D consecutive cycles.
- Ctrl outputs are registered from state/latched op.
  - At most one is ever high.
  - All are 0 in FETCH.
- instr is sampled only in FETCH; changes during EXEC are ignored.
- Registers:
  - rsel >= NUM_REGS: set/dec have no effect; jz/jnz read such a register as 0.
  - dec wraps 0 -> FFFF.
- pc arithmetic is 8-bit: 255+1 wraps to 0.
- ena=0:
  - state, counter, pc and registers hold.
  - All ctrl outputs are forced 0.
  - Resumes exactly where it left off when ena returns to 1.
- Reset mid-EXEC aborts immediately; outputs are 0 in the same cycle reset is asserted.

Optional Feature:
- Macro: PROCESSOR_HALT_EN.
- Defined:
  - Adds output port halted (1 bit, reset 0).
  - Opcode FF in FETCH sets halted=1 and freezes pc and state permanently; ctrl outputs stay 0.
  - Only rst clears halted.
- Undefined: FF is an ordinary NOP, and the halted port does not exist.

Test Plan:
- Reset, then instr = fill, imm=0x0020 -> ctrl_fill low 1 cycle, then high exactly 32 cycles; pc 0->1 at cycle 33; no other ctrl output ever high.
- release imm=0x0030, forward imm=0x0040, reverse imm=0x0050, wait imm=0x0060 -> respective output high 48/64/80/0 cycles; each instruction totals imm+1 cycles; pc increments once per instruction.
- set R0=0x00AB, dec R0, jz R0 target 0xCD -> not taken, pc+1; set R0=0, jz R0 target 0xEF -> pc=0xEF.
- set R1=0x00EA, jz R1 target 0xFE -> pc+1; jnz R1 target 0xFE -> pc=0xFE.
- ena=0 for 10 cycles in the middle of fill imm=20 -> ctrl_fill drops during the pause; total high time still 20; pc unchanged during the pause.
- Assert rst during EXEC of forward imm=50 -> ctrl_forward=0 and pc=0 immediately; after release of reset, the processor restarts fetching at pc 0.

Source files
------------

// File: rtl/washer_processor_if.sv
// Bus bundle between the washer sequencer core and its program memory / actuators.
// Optional PROCESSOR_HALT_EN adds the halted status line.
interface washer_processor_if;
  logic        ena;
  logic [31:0] instr;
  logic [7:0]  pc;
  logic        ctrl_fill;
  logic        ctrl_release;
  logic        ctrl_forward;
  logic        ctrl_reverse;
`ifdef PROCESSOR_HALT_EN
  logic        halted;

  modport master (
    input  ena, instr,
    output pc, ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse, halted
  );
  modport slave (
    output ena, instr,
    input  pc, ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse, halted
  );
`else
  modport master (
    input  ena, instr,
    output pc, ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse
  );
  modport slave (
    output ena, instr,
    input  pc, ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse
  );
`endif
endinterface

// File: rtl/washer_processor.sv
// Washing-machine sequencer core: timed actuator ops plus register loops.
// Optional PROCESSOR_HALT_EN makes opcode FF a permanent halt.
//
// state | meaning
// FETCH | decode instr at pc; untimed ops complete here in one cycle
// EXEC  | timed op running; counter counts down to 1, then pc+1
module washer_processor #(
  parameter int NUM_REGS = 4
) (
  input logic               clk,
  input logic               rst,
  washer_processor_if.master bus
);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] regs_q [NUM_REGS];
  logic        reg_we;
  logic [15:0] reg_wdata;
  logic        run;

  logic [7:0]    op, rsel;
  logic [15:0]   imm;
  logic          rsel_ok;
  logic [IW-1:0] ridx;
  logic [15:0]   rdata;

  assign op      = bus.instr[7:0];
  assign rsel    = bus.instr[15:8];
  assign imm     = bus.instr[31:16];
  assign rsel_ok = 32'(rsel) < NUM_REGS;
  assign ridx    = rsel[IW-1:0];
  // Out-of-range register indices read as zero so they never alias real registers.
  assign rdata   = rsel_ok ? regs_q[ridx] : 16'h0000;

`ifdef PROCESSOR_HALT_EN
  logic halted_q, halt_d;
  assign run        = bus.ena & ~halted_q;
  assign bus.halted = halted_q;
`else
  assign run = bus.ena;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= 8'h00;
      op_q    <= 8'h00;
      cnt_q   <= 16'h0000;
`ifdef PROCESSOR_HALT_EN
      halted_q <= 1'b0;
`endif
    end else if (run) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
`ifdef PROCESSOR_HALT_EN
      halted_q <= halt_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 16'h0000;
    end else if (run && reg_we) begin
      regs_q[ridx] <= reg_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    reg_we    = 1'b0;
    reg_wdata = rdata;
`ifdef PROCESSOR_HALT_EN
    halt_d    = halted_q;
`endif
    case (state_q)
      FETCH: begin
        case (op)
          8'h01, 8'h02, 8'h03, 8'h04, 8'h05: begin
            if (imm != 16'h0000) begin
              op_d    = op;
              cnt_d   = imm;
              state_d = EXEC;
            end else begin
              pc_d = pc_q + 8'd1;
            end
          end
          8'h11: begin
            reg_we    = rsel_ok;
            reg_wdata = imm;
            pc_d      = pc_q + 8'd1;
          end
          8'h12: begin
            reg_we    = rsel_ok;
            reg_wdata = rdata - 16'd1;
            pc_d      = pc_q + 8'd1;
          end
          8'h21: pc_d = (rdata == 16'h0000) ? imm[7:0] : pc_q + 8'd1;
          8'h22: pc_d = (rdata != 16'h0000) ? imm[7:0] : pc_q + 8'd1;
`ifdef PROCESSOR_HALT_EN
          8'hFF: halt_d = 1'b1;
`endif
          default: pc_d = pc_q + 8'd1;
        endcase
      end
      EXEC: begin
        if (cnt_q == 16'd1) begin
          cnt_d   = 16'h0000;
          pc_d    = pc_q + 8'd1;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Gated by run so a pause drops the actuators in the same cycle.
  always_comb begin
    bus.ctrl_fill    = 1'b0;
    bus.ctrl_release = 1'b0;
    bus.ctrl_forward = 1'b0;
    bus.ctrl_reverse = 1'b0;
    if (state_q == EXEC && run) begin
      case (op_q)
        8'h02:   bus.ctrl_fill    = 1'b1;
        8'h03:   bus.ctrl_release = 1'b1;
        8'h04:   bus.ctrl_forward = 1'b1;
        8'h05:   bus.ctrl_reverse = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.pc = pc_q;
endmodule

// File: tb/tb_washer_processor.sv
// Directed bench for washer_processor: timed ops, register loops, pause and reset abort.
module tb_washer_processor;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   onehot_bad = 0;
  logic [31:0] mem [256];
  logic [3:0]  cvec;

  washer_processor_if bif ();

  washer_processor #(.NUM_REGS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  assign bif.instr = mem[bif.pc];
  assign cvec = {bif.ctrl_reverse, bif.ctrl_forward, bif.ctrl_release, bif.ctrl_fill};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if ($countones(cvec) > 1) onehot_bad++;

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] rs,
                                      input logic [15:0] imm);
    return {imm, rs, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs the instruction at the current pc until pc moves; idx: 0 fill,1 release,2 fwd,3 rev,-1 none.
  task automatic run_instr(input string tag, input logic [7:0] exp_pc, input int exp_cyc,
                           input int exp_idx, input int exp_high);
    logic [7:0] pc0;
    logic [3:0] first;
    int n, high, other;
    pc0 = bif.pc; first = cvec; n = 0; high = 0; other = 0;
    while (n < 200) begin
      for (int k = 0; k < 4; k++)
        if (cvec[k]) begin
          if (k == exp_idx) high++;
          else other++;
        end
      @(negedge clk);
      n++;
      if (bif.pc !== pc0) break;
    end
    check({tag, "_cycles"}, n, exp_cyc);
    check({tag, "_pc"}, {24'h0, bif.pc}, {24'h0, exp_pc});
    check({tag, "_high"}, high, exp_high);
    check({tag, "_other"}, other, 0);
    check({tag, "_fetch_low"}, {28'h0, first}, 32'h0);
  endtask

  initial begin
    logic [7:0] pc0;
    int n, high, other, phigh, pmove;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = ins(8'h02, 8'd0, 16'h0020);
    mem[8'h01] = ins(8'h03, 8'd0, 16'h0030);
    mem[8'h02] = ins(8'h04, 8'd0, 16'h0040);
    mem[8'h03] = ins(8'h05, 8'd0, 16'h0050);
    mem[8'h04] = ins(8'h01, 8'd0, 16'h0060);
    mem[8'h05] = ins(8'h02, 8'd0, 16'h0000);
    mem[8'h06] = ins(8'h11, 8'd0, 16'h00AB);
    mem[8'h07] = ins(8'h12, 8'd0, 16'h0000);
    mem[8'h08] = ins(8'h21, 8'd0, 16'h00CD);
    mem[8'h09] = ins(8'h11, 8'd0, 16'h0000);
    mem[8'h0A] = ins(8'h21, 8'd0, 16'h00EF);
    mem[8'hEF] = ins(8'h11, 8'd1, 16'h00EA);
    mem[8'hF0] = ins(8'h21, 8'd1, 16'h00FE);
    mem[8'hF1] = ins(8'h22, 8'd1, 16'h00FE);
    mem[8'hFE] = ins(8'h12, 8'd2, 16'h0000);
    mem[8'hFF] = ins(8'h21, 8'd2, 16'h0030);
    mem[8'h20] = ins(8'h11, 8'd4, 16'h0001);
    mem[8'h21] = ins(8'h21, 8'd0, 16'h0030);
    mem[8'h30] = ins(8'h22, 8'd4, 16'h0040);
    mem[8'h31] = ins(8'h33, 8'd0, 16'h0000);
    mem[8'h32] = ins(8'hFF, 8'd0, 16'h0000);
    mem[8'h33] = ins(8'h02, 8'd0, 16'd20);
    mem[8'h34] = ins(8'h04, 8'd0, 16'd50);

    rst = 1'b1;
    bif.ena = 1'b1;
    #1;
    check("reset_pc", {24'h0, bif.pc}, 32'h0);
    check("reset_ctrl", {28'h0, cvec}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_instr("fill", 8'h01, 33, 0, 32);
    mem[8'h00] = ins(8'h22, 8'd2, 16'h0020);
    run_instr("release", 8'h02, 49, 1, 48);
    run_instr("forward", 8'h03, 65, 2, 64);
    run_instr("reverse", 8'h04, 81, 3, 80);
    run_instr("wait", 8'h05, 97, -1, 0);
    run_instr("fill_zero", 8'h06, 1, -1, 0);
    run_instr("set_r0", 8'h07, 1, -1, 0);
    run_instr("dec_r0", 8'h08, 1, -1, 0);
    run_instr("jz_nt", 8'h09, 1, -1, 0);
    run_instr("set_r0_0", 8'h0A, 1, -1, 0);
    run_instr("jz_t", 8'hEF, 1, -1, 0);
    run_instr("set_r1", 8'hF0, 1, -1, 0);
    run_instr("jz_r1_nt", 8'hF1, 1, -1, 0);
    run_instr("jnz_r1_t", 8'hFE, 1, -1, 0);
    run_instr("dec_wrap", 8'hFF, 1, -1, 0);
    run_instr("pc_wrap", 8'h00, 1, -1, 0);
    run_instr("jnz_r2_t", 8'h20, 1, -1, 0);
    run_instr("set_bad_reg", 8'h21, 1, -1, 0);
    run_instr("jz_r0_noalias", 8'h30, 1, -1, 0);
    run_instr("jnz_bad_reg", 8'h31, 1, -1, 0);
    run_instr("nop", 8'h32, 1, -1, 0);
    run_instr("ff_nop", 8'h33, 1, -1, 0);

    // Pause mid-fill; also rewrite the fetched word to show it is ignored in EXEC.
    pc0 = bif.pc; n = 0; high = 0; other = 0; phigh = 0; pmove = 0;
    while (n < 200) begin
      if (n == 5) bif.ena = 1'b0;
      if (n == 8) mem[8'h33] = ins(8'h04, 8'd0, 16'd3);
      if (n == 15) bif.ena = 1'b1;
      #1;
      if (n >= 5 && n < 15) begin
        if (cvec != 4'b0000) phigh++;
        if (bif.pc !== pc0) pmove++;
      end
      if (bif.ctrl_fill) high++;
      if (cvec[3:1] != 3'b000) other++;
      @(negedge clk);
      n++;
      if (bif.pc !== pc0) break;
    end
    check("pause_cycles", n, 31);
    check("pause_fill_high", high, 20);
    check("pause_ctrl_low", phigh, 0);
    check("pause_pc_hold", pmove, 0);
    check("pause_other", other, 0);
    check("pause_pc_next", {24'h0, bif.pc}, 32'h34);

    repeat (10) @(negedge clk);
    check("fwd_running", {31'h0, bif.ctrl_forward}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort_fwd", {31'h0, bif.ctrl_forward}, 32'h0);
    check("abort_pc", {24'h0, bif.pc}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_instr("post_rst_regs", 8'h01, 1, -1, 0);
    run_instr("post_rst_release", 8'h02, 49, 1, 48);

    check("onehot", onehot_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
